// File: rtl/sram_responder_pkg.sv
// sram_responder_params: shared types for the SRAM responder.
//   ResponderState - CLEAR (zero-fill after reset) / READY (serving both ports)
//   Word           - one 32-bit memory word
//   PortRequest    - one port's request for the current cycle
//   merge_bytes    - replace the strobed bytes of a word with new data
package sram_responder_params;

    typedef enum logic {CLEAR, READY} ResponderState;

    typedef logic [31:0] Word;

    typedef struct packed {
        logic       enabled;
        logic [3:0] strobe;
        logic [31:0] address;
        Word        write_data;
    } PortRequest;

    function automatic Word merge_bytes(Word base, Word update, logic [3:0] strobe);
        Word result;
        result = base;
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
                result[8*b +: 8] = update[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: instruction and data SRAM buses between the core and the responder.
//   instruction_* / data_*: enable, byte strobe, byte address, write data, read data.
//   modport master: the core side (drives requests, receives read data).
//   modport slave : the responder side.
interface sram_responder_if;

    logic        instruction_enabled;
    logic [3:0]  instruction_write_strobe;
    logic [31:0] instruction_address;
    logic [31:0] instruction_write_data;
    logic [31:0] instruction_read_data;

    logic        data_enabled;
    logic [3:0]  data_write_enabled;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;

    modport master (
        output instruction_enabled, instruction_write_strobe, instruction_address,
               instruction_write_data,
        input  instruction_read_data,
        output data_enabled, data_write_enabled, data_address, data_write_data,
        input  data_read_data
    );

    modport slave (
        input  instruction_enabled, instruction_write_strobe, instruction_address,
               instruction_write_data,
        output instruction_read_data,
        input  data_enabled, data_write_enabled, data_address, data_write_data,
        output data_read_data
    );

endinterface

// File: rtl/sram_byte_bank.sv
// sram_byte_bank: 2^ADDRESS_WIDTH x 32-bit word array with two byte-strobed write ports
// and two read-first registered read ports.
//   clock, reset       - rising-edge clock, synchronous active-high reset (read registers only)
//   a_* / b_*          - read enable, zero-force, word index, write strobe, write data, read data
// Port b wins every byte both ports strobe when they write the same word.
module sram_byte_bank
    import sram_responder_params::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_read,
    input  logic                     a_zero,
    input  logic [ADDRESS_WIDTH-1:0] a_index,
    input  logic [3:0]               a_strobe,
    input  Word                      a_write_data,
    output Word                      a_read_data,
    input  logic                     b_read,
    input  logic                     b_zero,
    input  logic [ADDRESS_WIDTH-1:0] b_index,
    input  logic [3:0]               b_strobe,
    input  Word                      b_write_data,
    output Word                      b_read_data
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    Word  words [DEPTH];
    Word  a_read_data_q, b_read_data_q;
    logic collide;

    assign collide = (a_strobe != 4'b0) && (b_strobe != 4'b0) && (a_index == b_index);

    // A collision is written as one merged word so neither port's bytes are lost.
    always_ff @(posedge clock) begin
        if (collide) begin
            words[b_index] <= merge_bytes(merge_bytes(words[b_index], a_write_data, a_strobe),
                                          b_write_data, b_strobe);
        end else begin
            if (a_strobe != 4'b0) begin
                words[a_index] <= merge_bytes(words[a_index], a_write_data, a_strobe);
            end
            if (b_strobe != 4'b0) begin
                words[b_index] <= merge_bytes(words[b_index], b_write_data, b_strobe);
            end
        end
    end

    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            a_read_data_q <= '0;
            b_read_data_q <= '0;
        end else begin
            if (a_read) a_read_data_q <= a_zero ? '0 : words[a_index];
            if (b_read) b_read_data_q <= b_zero ? '0 : words[b_index];
        end
    end

    assign a_read_data = a_read_data_q;
    assign b_read_data = b_read_data_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the core's instruction and data SRAM ports.
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   bus            - sram_responder_if.slave, both request/response ports
//   init_done      - high once the zero-fill has finished and both ports are served
//   address_error  - sticky: set by any enabled access beyond the memory, cleared by reset
// After reset the array is zero-filled one word per cycle through bank port b; requests are
// ignored (and read data held at zero) until READY.
module sram_responder
    import sram_responder_params::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    sram_responder_if.slave   bus,
    output logic              init_done,
    output logic              address_error
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

    ResponderState              state_q;
    logic [ADDRESS_WIDTH-1:0]   clear_index_q;
    logic                       init_done_q;
    logic                       address_error_q;

    PortRequest instruction_request, data_request;
    logic       instruction_out_of_range, data_out_of_range;

    logic                     bank_a_read, bank_a_zero, bank_b_read, bank_b_zero;
    logic [ADDRESS_WIDTH-1:0] bank_a_index, bank_b_index;
    logic [3:0]               bank_a_strobe, bank_b_strobe;
    Word                      bank_a_write_data, bank_b_write_data;
    Word                      bank_a_read_data, bank_b_read_data;

    assign instruction_request = '{enabled:    bus.instruction_enabled,
                                   strobe:     bus.instruction_write_strobe,
                                   address:    bus.instruction_address,
                                   write_data: bus.instruction_write_data};
    assign data_request = '{enabled:    bus.data_enabled,
                            strobe:     bus.data_write_enabled,
                            address:    bus.data_address,
                            write_data: bus.data_write_data};

    assign instruction_out_of_range = |instruction_request.address[31:ADDRESS_WIDTH+2];
    assign data_out_of_range        = |data_request.address[31:ADDRESS_WIDTH+2];

    always_comb begin
        // CLEAR: port a idle, port b zero-fills, both read registers forced to zero.
        bank_a_read       = 1'b1;
        bank_a_zero       = 1'b1;
        bank_a_index      = instruction_request.address[ADDRESS_WIDTH+1:2];
        bank_a_strobe     = 4'b0;
        bank_a_write_data = instruction_request.write_data;
        bank_b_read       = 1'b1;
        bank_b_zero       = 1'b1;
        bank_b_index      = clear_index_q;
        bank_b_strobe     = 4'b1111;
        bank_b_write_data = '0;
        if (state_q == READY) begin
            bank_a_read   = instruction_request.enabled;
            bank_a_zero   = instruction_out_of_range;
            bank_a_strobe = (instruction_request.enabled && !instruction_out_of_range) ?
                            instruction_request.strobe : 4'b0;
            bank_b_read       = data_request.enabled;
            bank_b_zero       = data_out_of_range;
            bank_b_index      = data_request.address[ADDRESS_WIDTH+1:2];
            bank_b_strobe     = (data_request.enabled && !data_out_of_range) ?
                                data_request.strobe : 4'b0;
            bank_b_write_data = data_request.write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= CLEAR_ON_RESET ? CLEAR : READY;
            clear_index_q   <= '0;
            init_done_q     <= 1'b0;
            address_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    clear_index_q <= clear_index_q + 1'b1;
                    if (clear_index_q == LAST_INDEX) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    init_done_q <= 1'b1;
                    if ((instruction_request.enabled && instruction_out_of_range) ||
                        (data_request.enabled && data_out_of_range)) begin
                        address_error_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    sram_byte_bank #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_bank (
        .clock        (clock),
        .reset        (reset),
        .a_read       (bank_a_read),
        .a_zero       (bank_a_zero),
        .a_index      (bank_a_index),
        .a_strobe     (bank_a_strobe),
        .a_write_data (bank_a_write_data),
        .a_read_data  (bank_a_read_data),
        .b_read       (bank_b_read),
        .b_zero       (bank_b_zero),
        .b_index      (bank_b_index),
        .b_strobe     (bank_b_strobe),
        .b_write_data (bank_b_write_data),
        .b_read_data  (bank_b_read_data)
    );

    assign bus.instruction_read_data = bank_a_read_data;
    assign bus.data_read_data        = bank_b_read_data;
    assign init_done                 = init_done_q;
    assign address_error             = address_error_q;

endmodule
